// File: rtl/data_mem_resp.sv
// Word-addressed 32-bit data memory answering one load/store at a time, LATENCY+1 cycles after the accept cycle.
// Optional macro DMEM_MISALIGN_ERR_EN: flag req_addr[1:0]!=0 as an error; without it the low address bits are ignored.
module data_mem_resp #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic MISALIGN_EN = 1'b1;
`else
    localparam logic MISALIGN_EN = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    logic               accept;
    logic               req_err;
    logic               enter_resp;

    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        wdata_q;
    logic [3:0]         be_q;
    logic               err_q;

    // View of the transaction being completed; with LATENCY=0 it is still on the request pins.
    logic               cur_we;
    logic [ADDR_W-1:0]  cur_addr;
    logic [31:0]        cur_wdata;
    logic [3:0]         cur_be;
    logic               cur_err;

    logic [31:0]        mem [DEPTH];

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign req_err    = (|req_addr[31:ADDR_W+2]) | (MISALIGN_EN & (|req_addr[1:0]));
    assign enter_resp = (state_nxt == S_RESP);

    assign cur_we    = (state == S_IDLE) ? req_we                   : we_q;
    assign cur_addr  = (state == S_IDLE) ? req_addr[ADDR_W+1:2]     : addr_q;
    assign cur_wdata = (state == S_IDLE) ? req_wdata                : wdata_q;
    assign cur_be    = (state == S_IDLE) ? req_be                   : be_q;
    assign cur_err   = (state == S_IDLE) ? req_err                  : err_q;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_nxt = S_RESP;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            be_q      <= 4'd0;
            err_q     <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr[ADDR_W+1:2];
                wdata_q <= req_wdata;
                be_q    <= req_be;
                err_q   <= req_err;
            end
            rsp_valid <= enter_resp;
            rsp_err   <= enter_resp && cur_err;
            if (enter_resp && !cur_we && !cur_err) begin
                rsp_rdata <= mem[cur_addr];
            end else begin
                rsp_rdata <= 32'd0;
            end
        end
    end

    // Storage is deliberately not reset; a store commits only on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!reset && enter_resp && cur_we && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_be[i]) begin
                    mem[cur_addr][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_resp.sv
// Self-checking bench for data_mem_resp (ADDR_W=10, LATENCY=2): directed table, multi-cycle sequences, random vs. model.
module tb_data_mem_resp;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int EXP_LAT = LATENCY + 1;
`ifdef DMEM_MISALIGN_ERR_EN
    localparam logic MIS = 1'b1;
`else
    localparam logic MIS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vt [13];

    logic [31:0] model_mem [1024];
    int          pool [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] be,
                                input logic [31:0] exp_rdata, input logic exp_err);
        vec_t v;
        v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.be = be;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    // Issues one request from an IDLE cycle and returns the response plus accept-to-response latency.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output logic err,
                        output int lat, output logic pulse_after);
        int n = 0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be; req_valid = 1'b1;
        while (!req_ready && n < 20) begin
            step;
            n++;
        end
        step;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            step;
            lat++;
        end
        rdata = rsp_rdata;
        err = rsp_err;
        step;
        pulse_after = rsp_valid;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        pa;
        int          acc;
        int          pulses;
        int          pcyc [$];

        vt[0]  = mk("st_full",     1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        vt[1]  = mk("ld_full",     1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
        vt[2]  = mk("st_byte0",    1'b1, 32'h10,   32'h000000AA, 4'h1, 32'h0, 1'b0);
        vt[3]  = mk("ld_merged",   1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
        vt[4]  = mk("ld_misalign", 1'b0, 32'h12,   32'h0,        4'h0,
                    MIS ? 32'h0 : 32'hDEADBEAA, MIS);
        vt[5]  = mk("st_be0",      1'b1, 32'h10,   32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        vt[6]  = mk("ld_after_be0",1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEAA, 1'b0);
        vt[7]  = mk("st_word0",    1'b1, 32'h0,    32'h01020304, 4'hF, 32'h0, 1'b0);
        vt[8]  = mk("ld_oob",      1'b0, 32'h1000, 32'h0,        4'h0, 32'h0, 1'b1);
        vt[9]  = mk("st_oob",      1'b1, 32'h1000, 32'h55555555, 4'hF, 32'h0, 1'b1);
        vt[10] = mk("ld_word0",    1'b0, 32'h0,    32'h0,        4'h0, 32'h01020304, 1'b0);
        vt[11] = mk("st_top",      1'b1, 32'hFFC,  32'hCAFEBABE, 4'hF, 32'h0, 1'b0);
        vt[12] = mk("ld_top",      1'b0, 32'hFFC,  32'h0,        4'h0, 32'hCAFEBABE, 1'b0);

        // Reset state
        step;
        step;
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
        reset = 1'b0;
        step;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

        // Directed table
        for (int i = 0; i < 13; i++) begin
            xact(vt[i].we, vt[i].addr, vt[i].wdata, vt[i].be, rd, er, lat, pa);
            chk({vt[i].name, "_rdata"}, rd, vt[i].exp_rdata);
            chk({vt[i].name, "_err"},   {31'd0, er}, {31'd0, vt[i].exp_err});
            chk({vt[i].name, "_lat"},   32'(lat), 32'(EXP_LAT));
            chk({vt[i].name, "_pulse"}, {31'd0, pa}, 32'd0);
        end

        // req_valid held high across three loads
        acc = 0;
        pcyc.delete();
        req_we = 1'b0; req_addr = 32'h10; req_be = 4'h0; req_valid = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (req_valid && req_ready) acc++;
            if (rsp_valid) begin
                pcyc.push_back(c);
                chk("hold_ready_in_resp", {31'd0, req_ready}, 32'd0);
            end
            if (c == 1 || c == 2) chk("hold_ready_in_wait", {31'd0, req_ready}, 32'd0);
            step;
            if (acc == 3) req_valid = 1'b0;
        end
        chk("hold_pulses", 32'(pcyc.size()), 32'd3);
        if (pcyc.size() == 3) begin
            chk("hold_gap1", 32'(pcyc[1] - pcyc[0]), 32'd4);
            chk("hold_gap2", 32'(pcyc[2] - pcyc[1]), 32'd4);
        end

        // Reset in the middle of a store
        xact(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, rd, er, lat, pa);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF; req_valid = 1'b1;
        chk("mid_rst_ready_before", {31'd0, req_ready}, 32'd1);
        step;
        req_valid = 1'b0;
        step;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        step;
        step;
        reset = 1'b0;
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) pulses++;
            step;
        end
        chk("mid_rst_no_rsp", 32'(pulses), 32'd0);
        chk("mid_rst_ready_after", {31'd0, req_ready}, 32'd1);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pa);
        chk("mid_rst_ld_rdata", rd, 32'hCAFEF00D);
        chk("mid_rst_ld_err", {31'd0, er}, 32'd0);

        // Random traffic against a word-array model
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(64, 1023);
            model_mem[pool[i]] = $urandom;
            xact(1'b1, 32'(pool[i]) << 2, model_mem[pool[i]], 4'hF, rd, er, lat, pa);
        end
        for (int i = 0; i < 8; i++) model_mem[pool[i]] = model_mem[pool[i]];
        for (int i = 0; i < 60; i++) begin
            int          w;
            logic        we;
            logic [31:0] addr;
            logic [31:0] wd;
            logic [3:0]  be;
            logic        oob;
            logic        exp_err;
            logic [31:0] exp_rd;
            w    = pool[$urandom_range(0, 7)];
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            be   = 4'($urandom_range(0, 15));
            addr = 32'(w) << 2;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'($urandom_range(0, 3));
            oob  = ($urandom_range(0, 7) == 0);
            if (oob) addr = addr | (32'd1 << $urandom_range(12, 31));
            exp_err = oob || (MIS && addr[1:0] != 2'b00);
            exp_rd  = (!we && !exp_err) ? model_mem[w] : 32'd0;
            if (we && !exp_err) begin
                for (int b = 0; b < 4; b++)
                    if (be[b]) model_mem[w][8*b +: 8] = wd[8*b +: 8];
            end
            xact(we, addr, wd, be, rd, er, lat, pa);
            chk("rnd_rdata", rd, exp_rd);
            chk("rnd_err", {31'd0, er}, {31'd0, exp_err});
            chk("rnd_lat", 32'(lat), 32'(EXP_LAT));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address bits (depth 2^ADDR_W words of 32 bits).
REQ-002 SHALL have parameter LATENCY, default 2, meaning wait cycles between request accept and response (legal 0..15).
REQ-003 SHALL have port clk, input, 1, meaning single clock, rising edge.
REQ-004 SHALL have port reset, input, 1, meaning asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning the micro presents a load/store request.
REQ-006 SHALL have port req_ready, output, 1, meaning the responder can accept a request.
REQ-007 SHALL have port req_we, input, 1, meaning 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32, meaning byte address.
REQ-009 SHALL have port req_wdata, input, 32, meaning store data.
REQ-010 SHALL have port req_be, input, 4, meaning store byte enables; bit i gates byte i.
REQ-011 SHALL have port rsp_valid, output, 1, meaning a one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata, output, 32, meaning load data.
REQ-013 SHALL have port rsp_err, output, 1, meaning the request failed, qualified by rsp_valid.

Function
REQ-014 SHALL implement the FSM IDLE -> WAIT -> RESP -> IDLE; with LATENCY=0, IDLE -> RESP directly.
REQ-015 SHALL drive req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a rising edge with req_valid=1 and req_ready=1, and register we/addr/wdata/be on that edge.
REQ-017 SHALL leave WAIT only after a down-counter loaded with LATENCY-1 at accept reaches 0.
REQ-018 SHALL drive rsp_valid=1 for exactly one cycle (RESP), LATENCY+1 cycles after the accept edge; there is no response backpressure.
REQ-019 SHALL commit a store on the edge entering RESP, writing only the bytes enabled by req_be; req_be=0 is a legal no-op store.
REQ-020 SHALL return the full addressed word on rsp_rdata for a load in RESP, and 0 for stores and errors.
REQ-021 SHALL make a load issued after a completed store to the same word return the merged stored data.
REQ-022 SHALL flag out-of-range requests (any req_addr[31:ADDR_W+2] bit set) with rsp_err=1, suppress the write, and still respond with the normal latency.
REQ-023 SHALL address words with req_addr[ADDR_W+1:2], ignoring req_addr[1:0] except as defined in REQ-030.
REQ-024 SHALL ignore req_valid outside IDLE, while held high with req_ready=0; a request is never queued.
REQ-025 SHALL allow back-to-back operation, accepting the next request in the cycle after RESP (IDLE).

Reset
REQ-026 SHALL, on reset, immediately force the FSM to IDLE, the counter to 0, req_ready=1 once reset deasserts, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-027 SHALL drop any pending request when reset asserts mid-operation: an uncommitted store is not written and no response is produced.
REQ-028 SHALL NOT clear memory contents on reset.

Configuration
REQ-029 SHALL use the macro DMEM_MISALIGN_ERR_EN to compile the misalignment check in or out.
REQ-030 SHALL, with DMEM_MISALIGN_ERR_EN defined, treat req_addr[1:0]!=0 with req_we=1 or a load as an error per REQ-022; without it, req_addr[1:0] are silently ignored.

Verification (LATENCY=2, ADDR_W=10)
REQ-031 Bench SHALL apply: store addr=0x10, wdata=0xDEADBEEF, be=0xF, then load 0x10 -> store ack rsp_valid 3 cycles after accept with err=0, then rdata=0xDEADBEEF.
REQ-032 Bench SHALL apply: store 0x10 wdata=0x000000AA, be=0x1 over 0xDEADBEEF, then load -> rdata=0xDEADBEAA.
REQ-033 Bench SHALL apply: load addr=0x00001000 -> rsp_err=1, rdata=0; a subsequent store to 0x1000 leaves memory unchanged.
REQ-034 Bench SHALL apply: req_valid held high for 3 consecutive requests -> req_ready low in WAIT/RESP, exactly 3 rsp_valid pulses spaced 4 cycles apart.
REQ-035 Bench SHALL apply: reset asserted one cycle after accepting store 0x20=0x12345678, then load 0x20 -> prior contents returned and no rsp_valid for the dropped store.
REQ-036 Bench SHALL apply: with DMEM_MISALIGN_ERR_EN, a load at 0x12 -> rsp_err=1; without the macro -> rsp_err=0 and the word at 0x10 is returned.
